// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encodings,
// the default frame header byte and the image length check.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } boot_state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hB0;

    // True when a word count would run past the top of instruction memory.
    function automatic logic len_too_big(input logic [15:0] n, input int unsigned capacity);
        return {16'd0, n} > capacity;
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid pulses in the
// same cycle as the fourth byte, with word already holding that byte.
module imem_boot_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift;
    logic [1:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= 24'd0;
            cnt   <= 2'd0;
        end else if (clr) begin
            shift <= 24'd0;
            cnt   <= 2'd0;
        end else if (byte_en) begin
            shift <= {shift[15:0], byte_in};
            cnt   <= cnt + 2'd1;
        end
    end

    assign word       = {shift, byte_in};
    assign word_valid = byte_en && (cnt == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image, writes it into instruction
// memory and holds the core until the image checksum is accepted.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   ST_IDLE   | hunting for the MAGIC header byte, junk discarded
//   ST_LEN_HI | expecting word count, high byte
//   ST_LEN_LO | expecting word count, low byte; range check
//   ST_DATA   | packing data bytes, one memory write per word
//   ST_CSUM   | comparing received checksum with running XOR
//   ST_DONE   | image accepted, core released
//   ST_ERROR  | length or checksum fault, core stays held
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 10,
    parameter int         BASE_ADDR  = 0,
    parameter logic [7:0] MAGIC      = MAGIC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int unsigned CAPACITY = int'((1 << ADDR_WIDTH) - BASE_ADDR);

    boot_state_t state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [7:0]  xor_acc;
    logic        we_q;
    logic        transfer;
    logic        pack_en;
    logic [31:0] pack_word;
    logic        pack_valid;

    assign in_ready = !restart && (state inside {ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM});
    assign transfer = in_valid && in_ready;
    assign pack_en  = transfer && (state == ST_DATA);

    // A strobe registered just before a restart must not reach memory.
    assign imem_we  = we_q && !restart;

    imem_boot_loader_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (restart),
        .byte_en    (pack_en),
        .byte_in    (in_data),
        .word       (pack_word),
        .word_valid (pack_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            len_hi     <= 8'd0;
            len        <= 16'd0;
            word_idx   <= 16'd0;
            xor_acc    <= 8'd0;
            we_q       <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (restart) begin
                state      <= ST_IDLE;
                len_hi     <= 8'd0;
                len        <= 16'd0;
                word_idx   <= 16'd0;
                xor_acc    <= 8'd0;
                cpu_hold   <= 1'b1;
                load_done  <= 1'b0;
                load_error <= 1'b0;
            end else if (transfer) begin
                case (state)
                    ST_IDLE: begin
                        if (in_data == MAGIC) state <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        len_hi <= in_data;
                        state  <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        len      <= {len_hi, in_data};
                        word_idx <= 16'd0;
                        xor_acc  <= 8'd0;
                        if (len_too_big({len_hi, in_data}, CAPACITY)) begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                        end else if ({len_hi, in_data} == 16'd0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        xor_acc <= xor_acc ^ in_data;
                        if (pack_valid) begin
                            we_q       <= 1'b1;
                            imem_wdata <= pack_word;
                            imem_addr  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_idx);
                            word_idx   <= word_idx + 16'd1;
                            if (word_idx == len - 16'd1) state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (in_data == xor_acc) begin
                            state     <= ST_DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected memory writes are queued as
// frames are driven and checked by a write monitor; status is checked per test.
module tb_imem_boot_loader;

    localparam int AW   = 10;
    localparam int BASE = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          restart;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;

    int vectors     = 0;
    int miscompares = 0;

    logic [AW+31:0] sb[$];
    logic [31:0]    words[0:3];
    logic [7:0]     run_csum;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MAGIC(8'hB0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write addr=%h data=%h, no write expected", imem_addr, imem_wdata);
            end else begin
                logic [AW+31:0] exp;
                exp = sb.pop_front();
                if ({imem_addr, imem_wdata} !== exp) begin
                    miscompares++;
                    $display("FAIL write got addr=%h data=%h, expected addr=%h data=%h",
                             imem_addr, imem_wdata, exp[AW+31:32], exp[31:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready got %b expected 1 for byte %h", in_ready, b);
        end
        @(posedge clk);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
        end
    endtask

    task automatic send_header(input logic [15:0] len);
        send_byte(8'hB0, 0);
        send_byte(len[15:8], 0);
        send_byte(len[7:0], 0);
        run_csum = 8'h00;
    endtask

    task automatic send_data(input int nbytes, input int gap);
        for (int i = 0; i < nbytes; i++) begin
            logic [31:0] w;
            logic [7:0]  b;
            w = words[i / 4];
            if ((i % 4) == 0 && (i + 4) <= nbytes)
                sb.push_back({AW'(BASE + i / 4), w});
            b = 8'(w >> (24 - 8 * (i % 4)));
            run_csum = run_csum ^ b;
            send_byte(b, gap);
        end
    endtask

    task automatic send_csum(input logic corrupt);
        send_byte(corrupt ? (run_csum ^ 8'h5A) : run_csum, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_status(input string name, input logic done, input logic err, input logic hold);
        vectors++;
        if ({load_done, load_error, cpu_hold} !== {done, err, hold}) begin
            miscompares++;
            $display("FAIL %s done/error/hold got %b%b%b expected %b%b%b",
                     name, load_done, load_error, cpu_hold, done, err, hold);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s pending writes got %0d expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_restart();
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_ready got %b expected 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        restart = 1'b0;
        #1;
        vectors++;
        if ({load_done, load_error, cpu_hold, in_ready} !== 4'b0011) begin
            miscompares++;
            $display("FAIL restart_state done/error/hold/ready got %b%b%b%b expected 0011",
                     load_done, load_error, cpu_hold, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error} !== {1'b0, AW'(0), 32'd0, 3'b100}) begin
            miscompares++;
            $display("FAIL reset we=%b addr=%h data=%h hold=%b done=%b err=%b expected 0 0 0 1 0 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_good_frame();
        words[0] = 32'h24080005; words[1] = 32'h2409000A;
        send_header(16'd2);
        send_data(8, 0);
        send_csum(1'b0);
        check_status("good_frame", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_bad_csum();
        do_restart();
        words[0] = 32'h24080005; words[1] = 32'h2409000A;
        send_header(16'd2);
        send_data(8, 0);
        send_csum(1'b1);
        check_status("bad_csum", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_junk_empty();
        do_restart();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_header(16'd0);
        send_csum(1'b0);
        check_status("junk_empty", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_too_long();
        do_restart();
        send_header(16'h0401);
        @(negedge clk);
        in_valid = 1'b0;
        check_status("too_long", 1'b0, 1'b1, 1'b1);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL too_long_ready got %b expected 0", in_ready);
        end
    endtask

    task automatic test_restart_mid();
        do_restart();
        words[0] = 32'hDEADBEEF; words[1] = 32'hCAFEF00D;
        send_header(16'd2);
        send_data(6, 0);
        do_restart();
        words[0] = 32'h3C011234; words[1] = 32'h34215678;
        send_header(16'd2);
        send_data(8, 0);
        send_csum(1'b0);
        check_status("restart_mid", 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({imem_addr, imem_wdata} !== {AW'(BASE + 1), 32'h34215678}) begin
            miscompares++;
            $display("FAIL restart_last_write got addr=%h data=%h expected %h %h",
                     imem_addr, imem_wdata, AW'(BASE + 1), 32'h34215678);
        end
    endtask

    task automatic test_reset_mid_gaps();
        do_restart();
        words[0] = 32'h8C020004; words[1] = 32'hAC030008;
        send_header(16'd2);
        send_data(5, 0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if ({imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error} !== {1'b0, AW'(0), 32'd0, 3'b100}) begin
                miscompares++;
                $display("FAIL reset_mid cycle %0d we=%b addr=%h data=%h hold=%b done=%b err=%b",
                         c, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        words[0] = 32'h00851020; words[1] = 32'h1000FFFF;
        send_header(16'd2);
        send_data(8, 2);
        send_csum(1'b0);
        check_status("reset_mid_gaps", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_junk_empty();
        test_too_long();
        test_restart_mid();
        test_reset_mid_gaps();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
